// File: rtl/button_debounce.sv
// Push-button conditioner: 2-flop synchronizer, 4-state debounce FSM, press/release strobes.
// Define BTN_LONG_PRESS_EN to compile in the hold counter and long_press_pulse; otherwise it is tied 0.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES   = 2000000,
  parameter int unsigned LONG_PRESS_CYCLES = 200000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse
);

  localparam logic [31:0] DEB_LAST = 32'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES < 2) begin : g_bad_params
    $error("button_debounce: DEBOUNCE_CYCLES and LONG_PRESS_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        sync_meta;
  logic        btn_sync;
  logic [31:0] deb_cnt;
  logic [31:0] deb_cnt_next;
  logic        level_next;
  logic        press_next;
  logic        release_next;

`ifdef BTN_LONG_PRESS_EN
  localparam logic [31:0] HOLD_LAST = 32'(LONG_PRESS_CYCLES - 1);

  logic [31:0] hold_cnt;
  logic [31:0] hold_cnt_next;
  logic        long_done;
  logic        long_done_next;
  logic        long_next;
`endif

  // Only btn_sync, the second stage, is allowed to reach the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= 1'b0;
      btn_sync  <= 1'b0;
    end else begin
      sync_meta <= btn_in;
      btn_sync  <= sync_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RELEASED;
      deb_cnt       <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_next;
      deb_cnt       <= deb_cnt_next;
      btn_level     <= level_next;
      press_pulse   <= press_next;
      release_pulse <= release_next;
    end
  end

`ifdef BTN_LONG_PRESS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt         <= '0;
      long_done        <= 1'b0;
      long_press_pulse <= 1'b0;
    end else begin
      hold_cnt         <= hold_cnt_next;
      long_done        <= long_done_next;
      long_press_pulse <= long_next;
    end
  end
`else
  assign long_press_pulse = 1'b0;
`endif

  always_comb begin
    state_next   = state;
    deb_cnt_next = deb_cnt;
    level_next   = btn_level;
    press_next   = 1'b0;
    release_next = 1'b0;
`ifdef BTN_LONG_PRESS_EN
    hold_cnt_next  = hold_cnt;
    long_done_next = long_done;
    long_next      = 1'b0;
`endif

    case (state)
      RELEASED: begin
        if (btn_sync) begin
          state_next   = PRESS_WAIT;
          deb_cnt_next = '0;
        end
      end

      PRESS_WAIT: begin
        if (!btn_sync) begin
          state_next = RELEASED;
        end else if (deb_cnt == DEB_LAST) begin
          state_next = PRESSED;
          level_next = 1'b1;
          press_next = 1'b1;
`ifdef BTN_LONG_PRESS_EN
          hold_cnt_next  = '0;
          long_done_next = 1'b0;
`endif
        end else begin
          deb_cnt_next = deb_cnt + 32'd1;
        end
      end

      PRESSED: begin
        if (!btn_sync) begin
          state_next   = RELEASE_WAIT;
          deb_cnt_next = '0;
        end else begin
`ifdef BTN_LONG_PRESS_EN
          // The counter parks at its last value; the fired flag keeps the strobe to one per press.
          if (hold_cnt != HOLD_LAST) begin
            hold_cnt_next = hold_cnt + 32'd1;
          end else if (!long_done) begin
            long_next      = 1'b1;
            long_done_next = 1'b1;
          end
`endif
        end
      end

      RELEASE_WAIT: begin
        if (btn_sync) begin
          state_next = PRESSED;
        end else if (deb_cnt == DEB_LAST) begin
          state_next   = RELEASED;
          level_next   = 1'b0;
          release_next = 1'b1;
        end else begin
          deb_cnt_next = deb_cnt + 32'd1;
        end
      end

      default: begin
        state_next = RELEASED;
      end
    endcase
  end

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce (DEBOUNCE_CYCLES=8, LONG_PRESS_CYCLES=32).
// Long-press expectations follow BTN_LONG_PRESS_EN exactly as the design build does.
module tb_button_debounce;

  localparam int unsigned DEB  = 8;
  localparam int unsigned LONG = 32;

  localparam logic [2:0] K_PRESS = 3'b100;
  localparam logic [2:0] K_REL   = 3'b010;
  localparam logic [2:0] K_LONG  = 3'b001;

  typedef struct {
    int         edge_no;
    logic [2:0] kind;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic long_press_pulse;

  int   edge_cnt = 0;
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;
  exp_t sb_q[$];

  button_debounce #(
    .DEBOUNCE_CYCLES  (DEB),
    .LONG_PRESS_CYCLES(LONG)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .btn_in          (btn_in),
    .btn_level       (btn_level),
    .press_pulse     (press_pulse),
    .release_pulse   (release_pulse),
    .long_press_pulse(long_press_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Edge numbers refer to the posedge that registered the strobe; observed on the following negedge.
  always @(negedge clk) begin
    logic [2:0] pulses;
    exp_t       e;
    if (mon_en) begin
      pulses = {press_pulse, release_pulse, long_press_pulse};
      if (sb_q.size() > 0 && sb_q[0].edge_no <= edge_cnt) begin
        e = sb_q.pop_front();
        total++;
        if (e.edge_no != edge_cnt || pulses !== e.kind) begin
          bad++;
          $display("[TB] FAIL pulse_edge%0d: got %b at edge %0d, want %b", e.edge_no, pulses, edge_cnt, e.kind);
        end
      end else if (pulses !== 3'b000) begin
        total++;
        bad++;
        $display("[TB] FAIL stray_pulse: got %b at edge %0d, want 000", pulses, edge_cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_to(input int e);
    while (edge_cnt < e) @(negedge clk);
  endtask

  task automatic push_exp(input int e, input logic [2:0] k);
    exp_t x;
    x.edge_no = e;
    x.kind    = k;
    sb_q.push_back(x);
  endtask

  task automatic test_reset;
    rst    = 1'b1;
    btn_in = 1'b0;
    repeat (3) @(negedge clk);
    total += 4;
    if (btn_level !== 1'b0) begin bad++; $display("[TB] FAIL reset_level: got %b want 0", btn_level); end
    if (press_pulse !== 1'b0) begin bad++; $display("[TB] FAIL reset_press: got %b want 0", press_pulse); end
    if (release_pulse !== 1'b0) begin bad++; $display("[TB] FAIL reset_release: got %b want 0", release_pulse); end
    if (long_press_pulse !== 1'b0) begin bad++; $display("[TB] FAIL reset_long: got %b want 0", long_press_pulse); end
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_press;
    int base;
    base = edge_cnt;
    btn_in = 1'b1;
    push_exp(base + 11, K_PRESS);
    push_exp(base + 31, K_REL);
    wait_to(base + 10);
    total++;
    if (btn_level !== 1'b0) begin bad++; $display("[TB] FAIL press_level_early: got %b want 0", btn_level); end
    wait_to(base + 11);
    total++;
    if (btn_level !== 1'b1) begin bad++; $display("[TB] FAIL press_level: got %b want 1", btn_level); end
    wait_to(base + 20);
    btn_in = 1'b0;
    wait_to(base + 30);
    total++;
    if (btn_level !== 1'b1) begin bad++; $display("[TB] FAIL release_level_early: got %b want 1", btn_level); end
    wait_to(base + 31);
    total++;
    if (btn_level !== 1'b0) begin bad++; $display("[TB] FAIL release_level: got %b want 0", btn_level); end
    wait_to(base + 34);
  endtask

  task automatic test_bounce;
    int base;
    int lens[2] = '{5, 8};
    foreach (lens[i]) begin
      base = edge_cnt;
      btn_in = 1'b1;
      wait_to(base + lens[i]);
      btn_in = 1'b0;
      wait_to(base + lens[i] + 12);
      total++;
      if (btn_level !== 1'b0) begin bad++; $display("[TB] FAIL bounce_len%0d_level: got %b want 0", lens[i], btn_level); end
    end
    // Nine high samples is the shortest burst the debouncer accepts.
    base = edge_cnt;
    btn_in = 1'b1;
    push_exp(base + 11, K_PRESS);
    push_exp(base + 20, K_REL);
    wait_to(base + 9);
    btn_in = 1'b0;
    wait_to(base + 11);
    total++;
    if (btn_level !== 1'b1) begin bad++; $display("[TB] FAIL min_press_level: got %b want 1", btn_level); end
    wait_to(base + 20);
    total++;
    if (btn_level !== 1'b0) begin bad++; $display("[TB] FAIL min_release_level: got %b want 0", btn_level); end
    wait_to(base + 24);
  endtask

  task automatic test_long_press;
    int base;
    base = edge_cnt;
    btn_in = 1'b1;
    push_exp(base + 11, K_PRESS);
`ifdef BTN_LONG_PRESS_EN
    push_exp(base + 11 + LONG, K_LONG);
`endif
    push_exp(base + 111, K_REL);
    wait_to(base + 11 + LONG);
    total++;
    if (btn_level !== 1'b1) begin bad++; $display("[TB] FAIL long_level: got %b want 1", btn_level); end
    wait_to(base + 100);
    btn_in = 1'b0;
    wait_to(base + 111);
    total++;
    if (btn_level !== 1'b0) begin bad++; $display("[TB] FAIL long_release_level: got %b want 0", btn_level); end
    wait_to(base + 114);
  endtask

  // Low at edges 16..18: four decision edges (18..21) skip the hold count, so the long strobe moves 43 -> 47.
  task automatic test_release_glitch;
    int base;
    base = edge_cnt;
    btn_in = 1'b1;
    push_exp(base + 11, K_PRESS);
`ifdef BTN_LONG_PRESS_EN
    push_exp(base + 11 + LONG + 4, K_LONG);
`endif
    push_exp(base + 71, K_REL);
    wait_to(base + 15);
    btn_in = 1'b0;
    wait_to(base + 18);
    btn_in = 1'b1;
    for (int e = 19; e <= 22; e++) begin
      wait_to(base + e);
      total++;
      if (btn_level !== 1'b1) begin bad++; $display("[TB] FAIL glitch_level_e%0d: got %b want 1", e, btn_level); end
    end
    wait_to(base + 60);
    btn_in = 1'b0;
    wait_to(base + 71);
    total++;
    if (btn_level !== 1'b0) begin bad++; $display("[TB] FAIL glitch_release_level: got %b want 0", btn_level); end
    wait_to(base + 74);
  endtask

  task automatic test_reset_mid_press;
    int base;
    base = edge_cnt;
    btn_in = 1'b1;
    push_exp(base + 11, K_PRESS);
    push_exp(base + 27, K_PRESS);
    push_exp(base + 51, K_REL);
    wait_to(base + 15);
    rst = 1'b1;
    wait_to(base + 16);
    rst = 1'b0;
    total++;
    if ({btn_level, press_pulse, release_pulse, long_press_pulse} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL midreset_outputs: got %b want 0000", {btn_level, press_pulse, release_pulse, long_press_pulse});
    end
    wait_to(base + 26);
    total++;
    if (btn_level !== 1'b0) begin bad++; $display("[TB] FAIL requal_level_early: got %b want 0", btn_level); end
    wait_to(base + 27);
    total++;
    if (btn_level !== 1'b1) begin bad++; $display("[TB] FAIL requal_level: got %b want 1", btn_level); end
    wait_to(base + 40);
    btn_in = 1'b0;
    wait_to(base + 54);
  endtask

  // Reset lands on the very edge that would have accepted the press.
  task automatic test_reset_priority;
    int base;
    base = edge_cnt;
    btn_in = 1'b1;
    push_exp(base + 22, K_PRESS);
    push_exp(base + 41, K_REL);
    wait_to(base + 10);
    rst = 1'b1;
    wait_to(base + 11);
    rst = 1'b0;
    total++;
    if (btn_level !== 1'b0) begin bad++; $display("[TB] FAIL prio_level: got %b want 0", btn_level); end
    wait_to(base + 22);
    total++;
    if (btn_level !== 1'b1) begin bad++; $display("[TB] FAIL prio_press_level: got %b want 1", btn_level); end
    wait_to(base + 30);
    btn_in = 1'b0;
    wait_to(base + 44);
  endtask

  task automatic test_back_to_back;
    int base;
    int highs[3] = '{12, 15, 20};
    foreach (highs[i]) begin
      base = edge_cnt;
      btn_in = 1'b1;
      push_exp(base + 11, K_PRESS);
      push_exp(base + highs[i] + 11, K_REL);
      wait_to(base + highs[i]);
      btn_in = 1'b0;
      wait_to(base + highs[i] + 11);
      total++;
      if (btn_level !== 1'b0) begin bad++; $display("[TB] FAIL b2b_%0d_level: got %b want 0", i, btn_level); end
    end
    wait_to(edge_cnt + 4);
  endtask

  initial begin
    rst    = 1'b1;
    btn_in = 1'b0;
    test_reset;
    test_press;
    test_bounce;
    test_long_press;
    test_release_glitch;
    test_reset_mid_press;
    test_reset_priority;
    test_back_to_back;
    repeat (4) @(negedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 2000000, stable-sample count to accept a level change (10 ms at 200 MHz); legal values >= 2.
REQ-002 Parameter LONG_PRESS_CYCLES, default 200000000, held-cycle count for a long press (1 s at 200 MHz); legal values >= 2.
REQ-003 Port clk, input, 1 bit, single system clock; all flops on posedge clk.
REQ-004 Port rst, input, 1 bit, reset; synchronous, active-high.
REQ-005 Port btn_in, input, 1 bit, raw asynchronous push-button level; 1 = pressed.
REQ-006 Port btn_level, output, 1 bit, debounced button level.
REQ-007 Port press_pulse, output, 1 bit, one-cycle strobe on accepted press.
REQ-008 Port release_pulse, output, 1 bit, one-cycle strobe on accepted release.
REQ-009 Port long_press_pulse, output, 1 bit, one-cycle strobe when a press reaches LONG_PRESS_CYCLES.

Function
REQ-010 btn_in SHALL pass through a 2-flop synchronizer; only its second stage (btn_sync) SHALL drive any logic.
REQ-011 FSM SHALL have exactly 4 states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-012 RELEASED: btn_sync=1 -> PRESS_WAIT, debounce counter <= 0; else stay.
REQ-013 PRESS_WAIT: btn_sync=0 -> RELEASED (bounce rejected, no pulse); btn_sync=1 and counter=DEBOUNCE_CYCLES-1 -> PRESSED; else counter +1.
REQ-014 PRESS_WAIT->PRESSED SHALL set btn_level=1, assert press_pulse for that one cycle, and clear the hold counter.
REQ-015 PRESSED: btn_sync=0 -> RELEASE_WAIT, debounce counter <= 0; else hold counter +1, saturating at LONG_PRESS_CYCLES-1.
REQ-016 long_press_pulse SHALL assert for one cycle exactly LONG_PRESS_CYCLES cycles after the press_pulse cycle if PRESSED was held throughout; at most once per accepted press.
REQ-017 RELEASE_WAIT: btn_sync=1 -> PRESSED (bounce rejected, no pulse, btn_level stays 1, hold counter frozen, not cleared); btn_sync=0 and counter=DEBOUNCE_CYCLES-1 -> RELEASED; else counter +1.
REQ-018 RELEASE_WAIT->RELEASED SHALL set btn_level=0 and assert release_pulse for that one cycle.
REQ-019 Latency: btn_in first sampled high at edge 1 and held -> btn_level/press_pulse registered at edge DEBOUNCE_CYCLES+3; release symmetric.
REQ-020 press_pulse, release_pulse, long_press_pulse SHALL never be high together; all outputs registered.
REQ-021 Counters SHALL be 32 bits, never wrap; debounce counter never exceeds DEBOUNCE_CYCLES-1.

Reset
REQ-022 rst=1 at a clock edge SHALL set state RELEASED, synchronizer flops 0, both counters 0, all outputs 0.
REQ-023 Reset mid-press (any state) SHALL abort without release_pulse; a btn_in still high after reset SHALL be requalified from RELEASED with full latency.
REQ-024 rst SHALL take priority over every transition in the same cycle.

Configuration
REQ-025 Macro BTN_LONG_PRESS_EN defined: hold counter and long-press logic compiled in per REQ-015..REQ-017.
REQ-026 BTN_LONG_PRESS_EN undefined: hold counter absent, long_press_pulse tied 0, LONG_PRESS_CYCLES ignored; all other behaviour identical.

Verification (DEBOUNCE_CYCLES=8, LONG_PRESS_CYCLES=32)
REQ-027 btn_in 0->1 held 20 cycles -> btn_level=1 and press_pulse single-cycle at edge 11; no other pulse.
REQ-028 btn_in high 5 cycles then low -> btn_level stays 0, no pulses; FSM back in RELEASED.
REQ-029 Accepted press, btn_in low 3 cycles then high -> no release_pulse, btn_level stays 1; long_press_pulse delayed by the RELEASE_WAIT cycles (macro defined).
REQ-030 Press held 100 cycles, macro defined -> exactly one long_press_pulse 32 cycles after press_pulse; macro undefined -> long_press_pulse never 1.
REQ-031 Press accepted, rst pulsed 1 cycle while btn_in high -> outputs 0 next cycle, no release_pulse, new press_pulse 11 edges after rst deasserts.
